// File: rtl/reg_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : reg_scan_display
// Brief    : Walks every register-file address on a start key press, captures
//            each read value and holds it on the LED outputs for a dwell time
//            (auto mode) or until a step key press (manual mode).
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Key conditioning: 2-FF synchronizer followed by a registered falling-edge
// detector. One press produces exactly one single-cycle event, three clock
// edges after the key falls. Keys are assumed to be debounced upstream.
// ----------------------------------------------------------------------------
module reg_scan_key_cond (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic ev_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic ev_q;

  // Synchronize the raw key and register a pulse on its high-to-low transition
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      ev_q    <= 1'b0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ev_q    <= prev_q & ~sync2_q;
    end
  end

  assign ev_o = ev_q;

endmodule

// ----------------------------------------------------------------------------
// Scan controller
// ----------------------------------------------------------------------------
module reg_scan_display #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DWELL      = 50000000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start_n,
  input  logic                  step_n,
  input  logic                  manual,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  busy,
  output logic                  done
);

  // Counter only has to reach DWELL-1; keep at least one bit for DWELL == 1
  localparam int                    CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_ADVANCE = 3'd4
  } state_e;

  state_e                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   read_addr_q, read_addr_d;
  logic [DATA_WIDTH-1:0]   disp_data_q, disp_data_d;
  logic [ADDR_WIDTH-1:0]   disp_addr_q, disp_addr_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic                    done_d;
  logic                    start_ev;
  logic                    step_ev;
  logic                    busy_w;

  reg_scan_key_cond u_start_cond (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .key_ni (start_n),
    .ev_o   (start_ev)
  );

  reg_scan_key_cond u_step_cond (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .key_ni (step_n),
    .ev_o   (step_ev)
  );

  assign busy_w = (state_q != S_IDLE);

  // State, address, display and dwell-counter registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      read_addr_q <= '0;
      disp_data_q <= '0;
      disp_addr_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      read_addr_q <= read_addr_d;
      disp_data_q <= disp_data_d;
      disp_addr_q <= disp_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic; a start event while busy aborts and restarts the scan
  // ahead of any step event or dwell expiry in the same cycle
  always_comb begin
    state_d     = state_q;
    read_addr_d = read_addr_q;
    disp_data_d = disp_data_q;
    disp_addr_d = disp_addr_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    if (busy_w && start_ev) begin
      read_addr_d = '0;
      state_d     = S_SETUP;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            read_addr_d = '0;
            state_d     = S_SETUP;
          end
        end
        // read_addr is held stable for one full cycle before sampling, which
        // covers both a combinational and a one-cycle registered read port
        S_SETUP: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          disp_data_d = read_data;
          disp_addr_d = read_addr_q;
          cnt_d       = '0;
          state_d     = S_HOLD;
        end
        // Mode is re-sampled every cycle; the counter is frozen (not cleared)
        // while in manual mode so a later switch to auto resumes from it
        S_HOLD: begin
          if (manual) begin
            if (step_ev) begin
              state_d = S_ADVANCE;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_ADVANCE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Terminating at the top address means the address never wraps
        S_ADVANCE: begin
          if (read_addr_q == ADDR_MAX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            read_addr_d = read_addr_q + 1'b1;
            state_d     = S_SETUP;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign read_addr = read_addr_q;
  assign disp_data = disp_data_q;
  assign disp_addr = disp_addr_q;
  assign busy      = busy_w;
  assign done      = done_d;

endmodule
`default_nettype wire

// File: doc/reg_scan_display.md
Name: reg_scan_display

Overview:
- Read-side companion to the switch-driven register-file write path.
- On a KEY press, walks every register-file address in order and drives the read address port.
- Captures each read value and holds it on the LED outputs for a dwell period, or until a step key press in manual mode.
- Sits between the register file's second read port and the LEDR/LEDG outputs at the board top.

Parameters:
- DATA_WIDTH, 4, width of a register-file word.
- ADDR_WIDTH, 3, register-file address width; scan covers 0 .. 2**ADDR_WIDTH-1.
- DWELL, 50000000, CLOCK_50 cycles each captured value is held in auto mode; must be >= 1.

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- start_n  input  1  active-low start key (asynchronous, from KEY).
- step_n  input  1  active-low step key (asynchronous, from KEY); used only in manual mode.
- manual  input  1  level from SW; 1 = advance on step, 0 = advance on dwell timer.
- read_addr  output  ADDR_WIDTH  address to register-file read port.
- read_data  input  DATA_WIDTH  data from register-file read port.
- disp_data  output  DATA_WIDTH  captured value, to LEDR.
- disp_addr  output  ADDR_WIDTH  address of disp_data, to LEDG.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the last address's dwell/step completes.

Behaviour:
- Reset (async, RESET_N=0): state=IDLE; read_addr=0, disp_data=0, disp_addr=0, busy=0, done=0; dwell counter=0; synchronizer and edge-detect flops=1 (released key).
- Key conditioning: start_n and step_n each pass through a 2-FF synchronizer, then a falling-edge detector.
  - Each press yields exactly one 1-cycle event (start_ev, step_ev).
  - Event appears 3 cycles after the input falls.
  - No debounce in this block; keys are pre-debounced.
- State machine:
  - IDLE: busy=0. On start_ev: read_addr<=0, go SETUP.
  - SETUP: read_addr is stable for this full cycle, go CAPTURE.
  - CAPTURE: disp_data<=read_data, disp_addr<=read_addr, dwell counter<=0, go HOLD.
  - HOLD, auto mode (manual=0): counter increments each cycle; when counter==DWELL-1, go ADVANCE.
  - HOLD, manual mode (manual=1): stay until step_ev, then go ADVANCE.
  - manual is sampled every HOLD cycle; switching mid-hold takes effect the next cycle, and the counter is not reset.
  - ADVANCE, read_addr != max: read_addr<=read_addr+1, go SETUP.
  - ADVANCE, read_addr == max: done=1 for this cycle, read_addr unchanged, go IDLE.
- busy=1 in SETUP, CAPTURE, HOLD and ADVANCE.
- Capture latency: read_data is sampled 2 cycles after read_addr changes. This covers a combinational read or a 1-cycle registered read.
- Displayed values: disp_data/disp_addr hold their last values in IDLE; they are not cleared by done.
- Restart: start_ev in any busy state aborts the scan.
  - read_addr<=0, go SETUP; done is not asserted.
  - This restart takes priority over step_ev and over dwell expiry in the same cycle.
- step_ev outside HOLD, or in auto mode: ignored, not queued.
- Address arithmetic: unsigned ADDR_WIDTH; never wraps, because ADVANCE at max terminates the scan.
- Reset mid-scan: immediate return to reset values; no done pulse.

Test Plan:
1. DWELL=4, regs preloaded 0..7 = 3,1,4,1,5,9,2,6, manual=0, pulse start_n low
   -> busy rises 4 cycles after start_n falls.
   -> disp_addr/disp_data step through (0,3),(1,1),...,(7,6), each held 4 cycles, 7 cycles per address.
   -> done pulses once, then busy=0 with disp=(7,6).
2. manual=1, same preload, start, then three step_n presses
   -> disp_data=3, then 1, 4, 1 after each press.
   -> disp_data does not change without a press; busy stays 1.
3. step_n pressed while IDLE, and in auto mode during HOLD
   -> no change to read_addr, disp_data or state timing.
4. Auto scan at address 5, start_n pressed again
   -> read_addr returns to 0; disp_addr=0, disp_data=3 two cycles later; no done pulse.
   -> Same result when dwell expiry coincides with start_ev.
5. RESET_N driven low asynchronously mid-HOLD (between clock edges)
   -> all outputs 0 immediately, without waiting for a clock edge.
   -> after release, IDLE until the next start press.
6. start_n held low for 100 cycles
   -> exactly one scan start; no restart while held.
